icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between the core fetch port (inst_addr/inst_ce/inst_i)
//  and a slower backing instruction memory with a req/ack word handshake. Hits return the word in the

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_arrays.sv | 71 +++++++
 rtl/icache_dm.sv | 196 +++++++++++++++++++
 tb/tb_icache_dm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : icache_pkg                                                    |
// | Purpose: Shared types and constants for the direct-mapped instruction  |
// |          cache: FSM state encoding, the NOP returned on non-hit        |
// |          cycles, and address-field width helpers.                      |
// | Ports  : none (package)                                                |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WAIT1  = 2'd2
  } state_t;

  // addi x0, x0, 0 -- harmless filler presented whenever no hit is available
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Tag is whatever is left above index, offset and the 2 byte-select bits
  function automatic int tag_width(input int addr_w, input int lines,
                                   input int words_per_line);
    return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_arrays.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : icache_arrays                                                 |
// | Purpose: Tag and data storage plus per-line valid bits. One write port |
// |          (data word, tag, valid set) and one combinational read port.  |
// | Ports  : clk, rst_n          clock, sync active-low reset (valid only)  |
// |          rd_idx/rd_off       read address; rd_valid/rd_tag/rd_data out  |
// |          data_we/wr_idx/wr_off/wr_data  refill data word write         |
// |          tag_we/wr_tag       tag write for line wr_idx                  |
// |          valid_set           mark line wr_idx valid                     |
// |          valid_clr_all       invalidate every line (wins over set)      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module icache_arrays #(
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             data_we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             valid_set,
  input  logic             valid_clr_all
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFF_W;

  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][WORDS];
  logic [LINES-1:0] valid;

  // Tag and data contents are meaningless until the valid bit is set, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_arr[wr_idx][wr_off] <= wr_data;
    end
    if (tag_we) begin
      tag_arr[wr_idx] <= wr_tag;
    end
  end

  // A flush arriving together with the final refill beat must leave the
  // line invalid, hence clear takes priority over set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (valid_clr_all) begin
      valid <= '0;
    end else if (valid_set) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data  = data_arr[rd_idx][rd_off];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : icache_dm                                                     |
// | Purpose: Direct-mapped read-only instruction cache. Same-cycle hits;   |
// |          a miss stalls the core and refills one whole line from the    |
// |          backing memory, one word per req/ack beat. Saturating         |
// |          hit/miss performance counters.                                |
// | Ports  : clk, rst_n                 clock, sync active-low reset        |
// |          inst_ce_i, inst_addr_i     core fetch request                  |
// |          inst_o, stall_o            fetched word / fetch not satisfied  |
// |          flush_i                    invalidate all lines                |
// |          mem_req_o, mem_addr_o      refill beat request and address     |
// |          mem_ack_i, mem_rdata_i     beat accepted / refill data         |
// |          hit_cnt_o, miss_cnt_o      saturating perf counters            |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [31:0]       inst_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W = idx_width(LINES);
  localparam int OFF_W = off_width(WORDS_PER_LINE);
  localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  // ---------------------------------------------------------------------
  // Address split
  // ---------------------------------------------------------------------
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             byte_sel_unused;

  assign off             = inst_addr_i[OFF_W+1:2];
  assign idx             = inst_addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign tag             = inst_addr_i[ADDR_W-1:IDX_W+OFF_W+2];
  assign byte_sel_unused = ^inst_addr_i[1:0];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [OFF_W-1:0] beat;
  logic             poison;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;

  logic             hit;
  logic             start_fill;
  logic             beat_ack;
  logic             last_ack;

  // A flush in the same cycle as a fetch forces a miss: the line may be
  // about to disappear, and the refill is deferred to the next cycle.
  assign hit = inst_ce_i & rd_valid & (rd_tag == tag) & (state == IDLE) & ~flush_i;

  assign inst_o     = hit ? rd_data : NOP;
  assign stall_o    = (inst_ce_i & ~hit) | (state != IDLE);
  assign start_fill = (state == IDLE) & inst_ce_i & ~hit & ~flush_i;
  assign beat_ack   = (state == REFILL) & mem_ack_i;
  assign last_ack   = beat_ack & (beat == LAST_BEAT);

  // Refill always addresses the latched line base, never the live input
  assign mem_addr_o = {fill_tag, fill_idx, beat, 2'b00};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_fill) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req_o = 1'b1;
        if (last_ack) begin
          state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        // Bubble so the next cycle re-looks-up the held address as a hit
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Line base, beat counter, poison flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_tag <= '0;
      fill_idx <= '0;
      beat     <= '0;
      poison   <= 1'b0;
    end else begin
      if (start_fill) begin
        fill_tag <= tag;
        fill_idx <= idx;
        beat     <= '0;
        poison   <= 1'b0;
      end else begin
        if (beat_ack) begin
          // Wraps back to zero after the last beat
          beat <= beat + 1'b1;
        end
        // Line being fetched may be stale w.r.t. the flush; never mark it valid
        if ((state != IDLE) && flush_i) begin
          poison <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  icache_arrays #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_arrays (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_idx        (idx),
    .rd_off        (off),
    .rd_valid      (rd_valid),
    .rd_tag        (rd_tag),
    .rd_data       (rd_data),
    .data_we       (beat_ack),
    .wr_idx        (fill_idx),
    .wr_off        (beat),
    .wr_data       (mem_rdata_i),
    .tag_we        (last_ack),
    .wr_tag        (fill_tag),
    .valid_set     (last_ack & ~poison),
    .valid_clr_all (flush_i)
  );

  // ---------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (start_fill && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_icache_dm                                                  |
// | Purpose: Directed self-checking bench for icache_dm with a backing     |
// |          memory responder of configurable ack delay.                   |
// | Ports  : none                                                          |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_ce_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_o;
  logic        stall_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  int n_assert = 0;
  int n_fail   = 0;

  int          ack_delay = 0;
  int          unstable  = 0;
  logic [31:0] beat_log [$];

  always #5 clk = ~clk;

  icache_dm u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_ce_i   (inst_ce_i),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .stall_o     (stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  // Backing memory contents: a distinct word for every address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory: acks after ack_delay waiting cycles; records every beat
  // address and flags any change of address or dropped request mid-wait.
  initial begin : responder
    int          wait_cnt;
    logic [31:0] held_addr;
    wait_cnt  = 0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rst_n && mem_req_o) begin
        if (wait_cnt == 0) begin
          held_addr = mem_addr_o;
        end else if (mem_addr_o !== held_addr) begin
          unstable++;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          beat_log.push_back(mem_addr_o);
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        if (wait_cnt != 0) begin
          unstable++;
        end
        wait_cnt = 0;
      end
    end
  end

  // Present a fetch and hold it until stall_o drops; returns stall cycles,
  // the word and mem_req_o seen in the hit cycle. Returns at the next negedge.
  task automatic fetch(input logic [31:0] a, output int stalls,
                       output logic [31:0] instr, output logic req);
    inst_ce_i   = 1'b1;
    inst_addr_i = a;
    stalls      = 0;
    #1;
    while (stall_o === 1'b1 && stalls < 100) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check("fetch_timeout", {31'd0, stall_o}, 32'd0);
    instr = inst_o;
    req   = mem_req_o;
    @(negedge clk);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < beat_log.size()) ? beat_log[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          st;
    logic [31:0] ins;
    logic        rq;

    // ---- reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_inst",  inst_o, NOP_W);
    check("rst_req",   {31'd0, mem_req_o}, 32'd0);
    check("rst_hit",   hit_cnt_o, 32'd0);
    check("rst_miss",  miss_cnt_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- cold miss, ack every cycle
    beat_log.delete();
    fetch(32'h100, st, ins, rq);
    check("cold_stalls", st, 32'd6);
    check("cold_data",   ins, mem_word(32'h100));
    check("cold_beats",  beat_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cold_beat_addr", log_at(i), 32'h100 + 32'(4 * i));
    end
    #1;
    check("cold_miss_cnt", miss_cnt_o, 32'd1);
    check("cold_hit_cnt",  hit_cnt_o, 32'd1);

    // ---- sequential hits in the filled line
    for (int i = 1; i < 4; i++) begin
      fetch(32'h100 + 32'(4 * i), st, ins, rq);
      check("seq_stalls", st, 32'd0);
      check("seq_data",   ins, mem_word(32'h100 + 32'(4 * i)));
      check("seq_req",    {31'd0, rq}, 32'd0);
    end
    #1;
    check("seq_hit_cnt",  hit_cnt_o, 32'd4);
    check("seq_miss_cnt", miss_cnt_o, 32'd1);
    check("seq_no_beats", beat_log.size(), 32'd4);

    // ---- conflict on index 0: 0x500 evicts 0x100
    fetch(32'h500, st, ins, rq);
    check("conf_stalls_500", st, 32'd6);
    check("conf_data_500",   ins, mem_word(32'h500));
    fetch(32'h100, st, ins, rq);
    check("conf_stalls_100", st, 32'd6);
    check("conf_data_100",   ins, mem_word(32'h100));
    #1;
    check("conf_miss_cnt", miss_cnt_o, 32'd3);
    check("conf_hit_cnt",  hit_cnt_o, 32'd6);

    // ---- slow memory: 3 wait cycles per beat
    ack_delay = 3;
    beat_log.delete();
    fetch(32'h248, st, ins, rq);
    check("slow_stalls", st, 32'd18);
    check("slow_data",   ins, mem_word(32'h248));
    check("slow_stable", unstable, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("slow_beat_addr", log_at(i), 32'h240 + 32'(4 * i));
    end
    ack_delay = 0;

    // ---- flush in IDLE with a fetch of a resident line
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h104;
    flush_i     = 1'b1;
    #1;
    check("flush_idle_stall", {31'd0, stall_o}, 32'd1);
    check("flush_idle_inst",  inst_o, NOP_W);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle_req",  {31'd0, mem_req_o}, 32'd0);
    check("flush_idle_miss", miss_cnt_o, 32'd4);
    fetch(32'h104, st, ins, rq);
    check("flush_idle_stalls", st, 32'd6);
    check("flush_idle_data",   ins, mem_word(32'h104));

    // ---- flush during beat 2 of a refill
    beat_log.delete();
    inst_addr_i = 32'h38C;
    #1;
    check("fl_rf_stall0", {31'd0, stall_o}, 32'd1);
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("fl_rf_req_beat2", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    fetch(32'h38C, st, ins, rq);
    check("fl_rf_stalls", st, 32'd8);
    check("fl_rf_data",   ins, mem_word(32'h38C));
    check("fl_rf_beats",  beat_log.size(), 32'd8);
    check("fl_rf_rebase", log_at(4), 32'h380);
    #1;
    check("fl_rf_miss_cnt", miss_cnt_o, 32'd7);
    check("fl_rf_hit_cnt",  hit_cnt_o, 32'd9);

    // ---- reset during beat 1 of a refill
    inst_addr_i = 32'h600;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    inst_ce_i = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("mrst_req",   {31'd0, mem_req_o}, 32'd0);
    check("mrst_stall", {31'd0, stall_o}, 32'd0);
    check("mrst_hit",   hit_cnt_o, 32'd0);
    check("mrst_miss",  miss_cnt_o, 32'd0);
    @(negedge clk);
    beat_log.delete();
    fetch(32'h38C, st, ins, rq);
    check("mrst_invalid_stalls", st, 32'd6);
    check("mrst_data",           ins, mem_word(32'h38C));
    check("mrst_beat0",          log_at(0), 32'h380);
    #1;
    check("mrst_miss_cnt", miss_cnt_o, 32'd1);
    check("mrst_hit_cnt",  hit_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
